// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner.
// Drives one column low at a time, samples the rows on a slow scan tick, debounces
// press and release, and delivers one 4-bit key code per press over a valid/ack handshake.
// Optional auto-repeat while a key stays held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_TICKS   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_overflow
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);

  if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_TICKS must be at least 1");
  end
  if (REPEAT_TICKS < 4) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_TICKS must be at least 4");
  end

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_EMIT,
    S_HELD
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [DEB_W-1:0]    cnt_q, cnt_d;
  logic [DEB_W-1:0]    rel_cnt_q, rel_cnt_d;
  logic [3:0]          col_out_q, col_out_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic                key_overflow_q, key_overflow_d;

  logic                tick;
  logic [3:0]          row_low;
  logic                row_single;
  logic [1:0]          row_enc;
  logic [DEB_W-1:0]    cnt_inc;
  logic [DEB_W-1:0]    rel_inc;
  logic                rep_due;

  assign tick    = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign cnt_inc = cnt_q + 1'b1;
  assign rel_inc = rel_cnt_q + 1'b1;

  // Row decode: flag exactly-one-row-low and encode its index (index only meaningful then).
  always_comb begin
    row_low    = ~row_in;
    row_single = $onehot(row_low);
    row_enc    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) row_enc = 2'(i);
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc = rep_cnt_q + 1'b1;

  // Repeat timer: counts HELD ticks; after the first REPEAT_TICKS it reloads so that it
  // expires again every REPEAT_TICKS/4 ticks. Any pass through SCAN clears it.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_due   = 1'b0;
    if (state_q == S_SCAN) begin
      rep_cnt_d = '0;
    end else if (state_q == S_HELD && tick) begin
      if (rep_inc == REP_W'(REPEAT_TICKS)) begin
        rep_due   = 1'b1;
        rep_cnt_d = REP_W'(REPEAT_TICKS - REPEAT_TICKS / 4);
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_due = 1'b0;
`endif

  // Next-state logic for the scan/debounce FSM, the tick divider and the handshake outputs.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case leaves
    // one unassigned and no latch is inferred.
    state_d        = state_q;
    tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
    col_idx_d      = col_idx_q;
    row_idx_d      = row_idx_q;
    cnt_d          = cnt_q;
    rel_cnt_d      = rel_cnt_q;
    key_code_d     = key_code_q;
    key_valid_d    = key_valid_q;
    key_overflow_d = key_overflow_q;

    if (key_ack && key_valid_q) key_valid_d = 1'b0;

    case (state_q)
      S_SCAN: begin
        if (tick) begin
          if (row_single) begin
            row_idx_d = row_enc;
            cnt_d     = DEB_W'(1);
            state_d   = (DEBOUNCE_TICKS == 1) ? S_EMIT : S_DEBOUNCE;
          end else begin
            // Idle column or ghosting (2+ rows low): move on to the next column.
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      S_DEBOUNCE: begin
        if (tick) begin
          if (row_single && row_enc == row_idx_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_W'(DEBOUNCE_TICKS)) state_d = S_EMIT;
          end else begin
            cnt_d   = '0;
            state_d = S_SCAN;
          end
        end
      end

      S_EMIT: begin
        // An emission overrides a same-cycle ack; an unconsumed code is lost and flagged.
        key_code_d  = {row_idx_q, col_idx_q};
        key_valid_d = 1'b1;
        if (key_valid_q) key_overflow_d = 1'b1;
        cnt_d       = '0;
        rel_cnt_d   = '0;
        state_d     = S_HELD;
      end

      S_HELD: begin
        if (tick) begin
          if (row_in == 4'hF) begin
            if (rel_inc == DEB_W'(DEBOUNCE_TICKS)) begin
              rel_cnt_d = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = S_SCAN;
            end else begin
              rel_cnt_d = rel_inc;
            end
          end else begin
            rel_cnt_d = '0;
            if (rep_due) state_d = S_EMIT;
          end
        end
      end

      default: state_d = S_SCAN;
    endcase

    col_out_d  = ~(4'b0001 << col_idx_d);
    key_held_d = (state_d == S_HELD);
  end

  // State and registered outputs; a synchronous rst returns everything to reset values.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q        <= S_SCAN;
      tick_cnt_q     <= '0;
      col_idx_q      <= 2'd0;
      row_idx_q      <= 2'd0;
      cnt_q          <= '0;
      rel_cnt_q      <= '0;
      col_out_q      <= 4'hF;
      key_code_q     <= 4'h0;
      key_valid_q    <= 1'b0;
      key_held_q     <= 1'b0;
      key_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      col_idx_q      <= col_idx_d;
      row_idx_q      <= row_idx_d;
      cnt_q          <= cnt_d;
      rel_cnt_q      <= rel_cnt_d;
      col_out_q      <= col_out_d;
      key_code_q     <= key_code_d;
      key_valid_q    <= key_valid_d;
      key_held_q     <= key_held_d;
      key_overflow_q <= key_overflow_d;
    end
  end

  assign col_out      = col_out_q;
  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_held     = key_held_q;
  assign key_overflow = key_overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner.
// A small keypad model drives row_in from col_out; stimulus is aligned to scan ticks.
module tb_keypad_scanner;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_overflow;

  logic       key_down;
  logic       multi;
  logic [1:0] key_row;
  logic [1:0] key_col;

  int tb_div      = 0;
  int n_checks    = 0;
  int n_errors    = 0;
  int valid_rises = 0;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .REPEAT_TICKS  (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overflow(key_overflow)
  );

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    if (multi && !col_out[0])                row_in = 4'b1001;
    else if (key_down && !col_out[key_col])  row_in = 4'hF ^ (4'b0001 << key_row);
  end

  // Independent scan-tick reference: the DUT samples rows on edges where tb_div == TICK_DIV-1.
  always @(posedge clk) begin
    if (rst) tb_div <= 0;
    else     tb_div <= (tb_div == TICK_DIV - 1) ? 0 : tb_div + 1;
  end

  // Count rising edges of key_valid, sampled mid-cycle.
  always @(posedge clk) begin
    #2;
    if (key_valid && !valid_prev) valid_rises++;
    valid_prev = key_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge just before the next scan tick.
  task automatic tick_edge();
    @(negedge clk);
    while (tb_div != TICK_DIV - 1) @(negedge clk);
  endtask

  // Advance tick by tick until the given column is the one about to be sampled.
  task automatic wait_col(input logic [1:0] col);
    logic [3:0] want;
    int n;
    want = 4'hF ^ (4'b0001 << col);
    n = 0;
    do begin
      tick_edge();
      n++;
    end while (col_out != want && n < 16);
    check("scan_reaches_col", col_out, want);
  endtask

  // Clean press; returns on the falling edge after the EMIT cycle.
  task automatic press(input logic [1:0] row, input logic [1:0] col,
                       input bit ack_in_emit, input bit prev_valid);
    key_row = row;
    key_col = col;
    wait_col(col);
    key_down = 1'b1;
    tick_edge();
    tick_edge();
    check("valid_before_T2", key_valid, prev_valid);
    @(negedge clk);
    check("valid_in_emit_cycle", key_valid, prev_valid);
    check("held_in_emit_cycle", key_held, 0);
    if (ack_in_emit) key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("valid_after_emit", key_valid, 1);
    check("code_after_emit", key_code, {row, col});
    check("held_after_emit", key_held, 1);
  endtask

  // Release the key; held must stay up until the DEB-th released tick.
  task automatic release_key();
    tick_edge();
    key_down = 1'b0;
    repeat (DEB - 1) tick_edge();
    check("held_mid_release", key_held, 1);
    tick_edge();
    check("held_after_release", key_held, 0);
  endtask

  task automatic ack_key();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("valid_after_ack", key_valid, 0);
  endtask

  // One-cycle rst from any state, then the first post-reset column.
  task automatic reset_and_check();
    rst = 1'b1;
    @(negedge clk);
    check("rst_col_out", col_out, 4'hF);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_overflow", key_overflow, 0);
    check("rst_code", key_code, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_col", col_out, 4'b1110);
  endtask

  initial begin
    int r0;
    int rise_cyc[$];
    rst      = 1'b1;
    key_ack  = 1'b0;
    key_down = 1'b0;
    multi    = 1'b0;
    key_row  = 2'd0;
    key_col  = 2'd0;

    // 1. Reset values and column rotation.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_col_out", col_out, 4'hF);
    check("reset_valid", key_valid, 0);
    check("reset_overflow", key_overflow, 0);
    check("reset_code", key_code, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    check("first_col", col_out, 4'b1110);
    repeat (3) @(negedge clk);
    check("rot_col1", col_out, 4'b1101);
    repeat (4) @(negedge clk);
    check("rot_col2", col_out, 4'b1011);
    repeat (4) @(negedge clk);
    check("rot_col3", col_out, 4'b0111);
    repeat (4) @(negedge clk);
    check("rot_wrap", col_out, 4'b1110);

    // 2. Clean press row2/col1 -> code 1001, ack clears valid next clock.
    press(2'd2, 2'd1, 1'b0, 1'b0);
    check("clean_code", key_code, 4'b1001);
    ack_key();
    release_key();

    // 3. Bounce: two matching ticks, one high, then steady -> exactly one emission.
    r0 = valid_rises;
    key_row = 2'd3;
    key_col = 2'd0;
    wait_col(2'd0);
    key_down = 1'b1;
    tick_edge();
    tick_edge();
    key_down = 1'b0;
    tick_edge();
    check("bounce_no_valid", key_valid, 0);
    check("bounce_col_held", col_out, 4'b1110);
    key_down = 1'b1;
    tick_edge();
    tick_edge();
    check("bounce_still_no_valid", key_valid, 0);
    tick_edge();
    check("bounce_valid", key_valid, 1);
    check("bounce_code", key_code, 4'b1100);
    check("bounce_one_emission", valid_rises, r0 + 1);
    ack_key();
    release_key();

    // 4a. Two presses without ack -> second code wins, sticky overflow.
    press(2'd0, 2'd2, 1'b0, 1'b0);
    release_key();
    check("no_overflow_yet", key_overflow, 0);
    press(2'd3, 2'd3, 1'b0, 1'b1);
    check("overflow_set", key_overflow, 1);
    ack_key();
    release_key();
    check("overflow_sticky", key_overflow, 1);
    reset_and_check();

    // 4b. Ack in the EMIT cycle of a second press also sets overflow.
    press(2'd1, 2'd0, 1'b0, 1'b0);
    release_key();
    press(2'd2, 2'd3, 1'b1, 1'b1);
    check("ack_in_emit_overflow", key_overflow, 1);
    ack_key();
    release_key();
    reset_and_check();

    // 5. rst during DEBOUNCE.
    key_row = 2'd1;
    key_col = 2'd2;
    wait_col(2'd2);
    key_down = 1'b1;
    tick_edge();
    tick_edge();
    check("debounce_col_held", col_out, 4'b1011);
    key_down = 1'b0;
    reset_and_check();

    // 5. rst during HELD with a pending key.
    press(2'd0, 2'd1, 1'b0, 1'b0);
    key_down = 1'b0;
    reset_and_check();

    // 5. Multi-key on one column: ignored, scan keeps rotating.
    multi = 1'b1;
    wait_col(2'd0);
    r0 = valid_rises;
    tick_edge();
    check("multi_advances", col_out, 4'b1101);
    repeat (8) tick_edge();
    check("multi_rotating", col_out, 4'b1101);
    check("multi_no_emission", valid_rises, r0);
    check("multi_no_held", key_held, 0);
    multi = 1'b0;
    reset_and_check();

    // 6. Hold for 20 ticks with immediate acks.
    key_row = 2'd1;
    key_col = 2'd1;
    wait_col(2'd1);
    key_down = 1'b1;
    for (int c = 0; c < TICK_DIV * 20; c++) begin
      @(negedge clk);
      if (key_valid) begin
        if (!key_ack) rise_cyc.push_back(c);
        key_ack = 1'b1;
      end else begin
        key_ack = 1'b0;
      end
    end
    key_ack = 1'b0;
    check("hold_still_held", key_held, 1);
    check("hold_no_overflow", key_overflow, 0);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("repeat_emissions", rise_cyc.size(), 6);
    if (rise_cyc.size() >= 6) begin
      check("repeat_first_gap", rise_cyc[1] - rise_cyc[0], REP * TICK_DIV);
      check("repeat_second_gap", rise_cyc[2] - rise_cyc[1], (REP / 4) * TICK_DIV);
      check("repeat_last_gap", rise_cyc[5] - rise_cyc[4], (REP / 4) * TICK_DIV);
    end
`else
    check("single_emission", rise_cyc.size(), 1);
`endif
    if (rise_cyc.size() >= 1) check("hold_first_emit_cycle", rise_cyc[0], 9);
    key_down = 1'b0;
    repeat (DEB) tick_edge();
    check("hold_released", key_held, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
